countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 15 +
 rtl/countdown_prescaler.sv | 40 ++++
 rtl/countdown_timer.sv | 96 +++++++++
 tb/tb_countdown_timer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer.
// The optional COUNTDOWN_AUTO_RELOAD_EN macro is consumed in countdown_timer.sv.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PRESCALE = 1;

endpackage

// File: rtl/countdown_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles.
// The count freezes while en is low; clr restarts the division.
module countdown_prescaler
    import countdown_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_pass
            // No divider state needed: every enabled cycle is a tick.
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, clr};
            assign tick = en;
        end else begin : g_div
            localparam int CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt <= '0;
                else if (clr)
                    cnt <= '0;
                else if (en)
                    cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end

            assign tick = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, restart and a registered done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload load_val at terminal count.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic             busy_n, done_n;
    logic             ps_clr, ps_en, tick;

    countdown_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (ps_clr),
        .en   (ps_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        done_n  = 1'b0;
        ps_clr  = 1'b0;
        // A HOLD cycle that sees pause drop already counts, so a pause of N
        // cycles delays completion by exactly N cycles.
        ps_en   = (state == RUN || state == HOLD) && !pause && !start;

        if (start) begin
            ps_clr = 1'b1;
            q_n    = load_val;
            if (load_val == '0) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else begin
            case (state)
                RUN, HOLD: begin
                    if (pause) begin
                        state_n = HOLD;
                    end else begin
                        state_n = RUN;
                        if (tick) begin
                            if (q > WIDTH'(1)) begin
                                q_n = q - WIDTH'(1);
                            end else begin
                                done_n = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                q_n = load_val;
                                if (load_val == '0)
                                    state_n = DONE;
`else
                                q_n     = '0;
                                state_n = DONE;
`endif
                            end
                        end
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n == RUN) || (state_n == HOLD);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one PRESCALE=1 and one PRESCALE=4 instance.
// Expectations follow COUNTDOWN_AUTO_RELOAD_EN when it is defined.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, pause1, start4, pause4;
    logic [7:0] load1, load4;
    logic [7:0] q1, q4;
    logic       busy1, done1, busy4, done4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pause(pause1),
        .load_val(load1), .q(q1), .busy(busy1), .done(done1)
    );

    countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .pause(pause4),
        .load_val(load4), .q(q4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0; pause1 = 1'b0; load1 = '0;
        start4 = 1'b0; pause4 = 1'b0; load4 = '0;
        #1;
        check("rst_q",    32'(q1),    0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_q4",   32'(q4),    0);
        #10;
        rst = 1'b0;
        tick();

        // Basic count 5 -> 0
        load1 = 8'd5; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("basic_q",    32'(q1),    32'(5 - k));
            check("basic_busy", 32'(busy1), 1);
            check("basic_done", 32'(done1), 0);
            tick();
        end
        check("basic_done_at6", 32'(done1), 1);
        check("basic_q_at6",    32'(q1),    AR ? 32'd5 : 32'd0);
        check("basic_busy_at6", 32'(busy1), 32'(AR));
        tick();
        check("basic_done_1cyc", 32'(done1), 0);
        do_reset();

        // Zero load
        load1 = 8'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("zero_done", 32'(done1), 1);
        check("zero_busy", 32'(busy1), 0);
        check("zero_q",    32'(q1),    0);
        tick();
        check("zero_done_off", 32'(done1), 0);
        check("zero_busy_off", 32'(busy1), 0);

        // Pause 7 cycles at q=6
        load1 = 8'd10; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        check("pause_q_pre", 32'(q1), 6);
        pause1 = 1'b1;
        repeat (7) begin
            tick();
            check("pause_q_hold", 32'(q1),    6);
            check("pause_busy",   32'(busy1), 1);
            check("pause_done",   32'(done1), 0);
        end
        pause1 = 1'b0;
        for (int k = 5; k >= 1; k--) begin
            tick();
            check("pause_q_resume", 32'(q1), 32'(k));
        end
        tick();
        check("pause_done_at18", 32'(done1), 1);
        do_reset();

        // Restart coinciding with the terminal tick
        load1 = 8'd3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick();
        check("restart_q_pre", 32'(q1), 1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("restart_q",    32'(q1),    3);
        check("restart_done", 32'(done1), 0);
        check("restart_busy", 32'(busy1), 1);
        tick(); tick();
        check("restart_q_late", 32'(q1), 1);
        tick();
        check("restart_done_end", 32'(done1), 1);
        check("restart_q_end",    32'(q1),    AR ? 32'd3 : 32'd0);
        do_reset();

        // Asynchronous reset mid-count, then immediate start
        load1 = 8'd10; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (6) tick();
        check("rstmid_q_pre", 32'(q1), 4);
        rst = 1'b1;
        #1;
        check("rstmid_q_async",    32'(q1),    0);
        check("rstmid_busy_async", 32'(busy1), 0);
        check("rstmid_done_async", 32'(done1), 0);
        #1;
        rst = 1'b0;
        tick();
        check("rstmid_q_after",    32'(q1),    0);
        check("rstmid_done_after", 32'(done1), 0);
        load1 = 8'd2; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("post_rst_start_q",    32'(q1),    2);
        check("post_rst_start_busy", 32'(busy1), 1);
        tick();
        tick();
        check("post_rst_done", 32'(done1), 1);
        check("post_rst_q",    32'(q1),    AR ? 32'd2 : 32'd0);

        // Start during the done cycle
        load1 = 8'd1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("done_start_q",    32'(q1),    1);
        check("done_start_busy", 32'(busy1), 1);
        check("done_start_done", 32'(done1), 0);
        tick();
        check("done_start_done2", 32'(done1), 1);
        check("done_start_busy2", 32'(busy1), 32'(AR));
        do_reset();

        // Prescaled count, PRESCALE=4, load 2
        load4 = 8'd2; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ps_q_c1", 32'(q4), 2);
        for (int c = 2; c <= 8; c++) begin
            tick();
            check("ps_q",    32'(q4),    (c < 5) ? 32'd2 : 32'd1);
            check("ps_done", 32'(done4), 0);
        end
        tick();
        check("ps_done_at9", 32'(done4), 1);
        check("ps_q_at9",    32'(q4),    AR ? 32'd2 : 32'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        do_reset();
        load1 = 8'd3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (3) tick();
        check("ar_done_c4", 32'(done1), 1);
        check("ar_q_c4",    32'(q1),    3);
        check("ar_busy_c4", 32'(busy1), 1);
        tick();
        check("ar_done_c5", 32'(done1), 0);
        check("ar_busy_c5", 32'(busy1), 1);
        tick(); tick();
        check("ar_done_c7", 32'(done1), 1);
`else
        tick();
        check("noar_idle_q",    32'(q1),    0);
        check("noar_idle_busy", 32'(busy1), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
